// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_D  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating streak counter: counts consecutive data grants that made fetch wait.
module arb_starve_cnt
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  input  logic [STREAK_W-1:0] max,
  output logic [STREAK_W-1:0] count,
  output logic                at_max
);

  logic [STREAK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                       count_d = '0;
    else if (inc && count_q < max) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count  = count_q;
  assign at_max = (count_q >= max);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data wins
// ties unless fetch has waited STARVE_MAX consecutive data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  arb_state_e          state_q, state_d;
  logic                m_we_q, m_we_d;
  logic [1:0]          m_size_q, m_size_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STREAK_W-1:0] streak;
  logic                at_max, idle, gnt_d, gnt_if;

  assign idle   = (state_q == IDLE);
  assign gnt_d  = idle & d_req & (~if_req | ~at_max);
  assign gnt_if = idle & if_req & ~gnt_d;

  // Streak only moves on grants; a data grant with no fetch waiting is not starvation.
  arb_starve_cnt u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (gnt_d & if_req),
    .clr    (gnt_if | (gnt_d & ~if_req)),
    .max    (STREAK_W'(STARVE_MAX)),
    .count  (streak),
    .at_max (at_max)
  );

  always_comb begin
    state_d   = state_q;
    m_we_d    = m_we_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d   = SERVE_D;
          m_we_d    = d_we;
          m_size_d  = (d_size == 2'b11) ? SZ_WORD : d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (gnt_if) begin
          state_d  = SERVE_IF;
          m_we_d   = 1'b0;
          m_size_d = SZ_WORD;
          m_addr_d = if_addr;
        end
      end
      SERVE_IF, SERVE_D: if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_we_q    <= 1'b0;
      m_size_q  <= SZ_WORD;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_we_q    <= m_we_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_req   = (state_q == SERVE_IF) | (state_q == SERVE_D);
  assign m_we    = m_we_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  assign if_ack   = (state_q == SERVE_IF) & m_ready;
  assign d_ack    = (state_q == SERVE_D) & m_ready;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SMAX = 4;

  logic          clk = 1'b0, rst;
  logic          if_req, if_ack, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_ack, d_stall;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ready;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  // Model: which port owns the memory (0 none, 1 fetch, 2 data) and the access it issued.
  int          busy = 0, streak = 0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic        e_we = 1'b0;
  logic [1:0]  e_size = 2'b00;
  bit          if_acked = 0, d_acked = 0, log_en = 0;
  logic [31:0] log_q[$];

  task automatic cycle(input bit wait_neg);
    bit ea_if, ea_d;
    if (wait_neg) @(negedge clk);
    ea_if = (busy == 1) && m_ready;
    ea_d  = (busy == 2) && m_ready;
    chk("m_req", 32'(m_req), 32'(busy != 0));
    chk("m_addr", m_addr, e_addr);
    chk("m_we", 32'(m_we), 32'(e_we));
    chk("m_size", 32'(m_size), 32'(e_size));
    if (busy == 2 && e_we) chk("m_wdata", m_wdata, e_wdata);
    chk("if_ack", 32'(if_ack), 32'(ea_if));
    chk("d_ack", 32'(d_ack), 32'(ea_d));
    if (ea_if) chk("if_rdata", if_rdata, m_rdata);
    if (ea_d)  chk("d_rdata", d_rdata, m_rdata);
    chk("if_stall", 32'(if_stall), 32'(if_req && !ea_if));
    chk("d_stall", 32'(d_stall), 32'(d_req && !ea_d));
    if (log_en && m_req) log_q.push_back(m_addr);
    if_acked = ea_if;
    d_acked  = ea_d;
    if (!rst) begin
      busy = 0; streak = 0; e_we = 0; e_size = 0; e_addr = 0; e_wdata = 0;
    end else if (busy != 0) begin
      if (m_ready) busy = 0;
    end else if (d_req && (!if_req || streak < SMAX)) begin
      busy = 2; e_we = d_we; e_size = (d_size == 2'b11) ? 2'b00 : d_size;
      e_addr = d_addr; e_wdata = d_wdata;
      streak = if_req ? ((streak + 1 > SMAX) ? SMAX : streak + 1) : 0;
    end else if (if_req) begin
      busy = 1; e_we = 0; e_size = 0; e_addr = if_addr; streak = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_rand(input int p_if, input int p_d, input int p_rdy, input int p_rst);
    rst = ($urandom_range(99) >= p_rst);
    if (!if_req || if_acked) begin
      if_req = ($urandom_range(99) < p_if); if_addr = $urandom;
    end
    if (!d_req || d_acked) begin
      d_req = ($urandom_range(99) < p_d); d_we = $urandom_range(1);
      d_size = 2'($urandom_range(3)); d_addr = $urandom; d_wdata = $urandom;
    end
    m_ready = rst && ($urandom_range(99) < p_rdy);
    m_rdata = $urandom;
  endtask

  initial begin
    rst = 0; if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_size = 2'b10;
    d_addr = 32'h80; d_wdata = 0; m_ready = 0; m_rdata = 0;
    @(posedge clk); #1;
    cycle(1); cycle(1);
    // Out of reset: both requesting, data wins the first grant.
    rst = 1; m_ready = 1; m_rdata = 32'h1234_5678;
    cycle(1);
    @(negedge clk);
    chk("first_grant_d", m_addr, 32'h80);
    chk("first_d_ack", 32'(d_ack), 32'd1);
    cycle(0);
    d_req = 0;
    cycle(1); cycle(1);
    if_req = 0;
    cycle(1);

    // Fetch only.
    if_req = 1; if_addr = 32'h10; m_ready = 1; m_rdata = 32'h0050_0093;
    cycle(1);
    @(negedge clk);
    chk("fetch_m_req", 32'(m_req), 32'd1);
    chk("fetch_m_addr", m_addr, 32'h10);
    chk("fetch_m_we", 32'(m_we), 32'd0);
    chk("fetch_m_size", 32'(m_size), 32'd0);
    chk("fetch_ack", 32'(if_ack), 32'd1);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);
    cycle(0);
    if_req = 0;
    cycle(1);

    // Simultaneous: store first, fetch at next IDLE.
    if_req = 1; if_addr = 32'h20;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_size = 2'b01;
    cycle(1);
    @(negedge clk);
    chk("sim_store_we", 32'(m_we), 32'd1);
    chk("sim_store_size", 32'(m_size), 32'd1);
    chk("sim_store_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("sim_store_ack", 32'(d_ack), 32'd1);
    cycle(0);
    d_req = 0;
    cycle(1);
    @(negedge clk);
    chk("sim_fetch_addr", m_addr, 32'h20);
    chk("sim_fetch_ack", 32'(if_ack), 32'd1);
    cycle(0);
    if_req = 0;
    cycle(1);

    // Starvation: both held; expect D,D,D,D,IF twice.
    if_req = 1; if_addr = 32'h100;
    d_req = 1; d_we = 0; d_addr = 32'h200; d_size = 2'b00; m_ready = 1;
    log_q.delete(); log_en = 1;
    repeat (20) cycle(1);
    log_en = 0;
    chk("starve_len", 32'(log_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < log_q.size()) chk("starve_seq", log_q[i], (i % 5 == 4) ? 32'h100 : 32'h200);
    if_req = 0; d_req = 0;
    cycle(1);

    // Wait states on a store with reserved size.
    d_req = 1; d_we = 1; d_size = 2'b11; d_addr = 32'h300; d_wdata = 32'hA5A5_0F0F; m_ready = 0;
    cycle(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ws_addr", m_addr, 32'h300);
      chk("ws_size", 32'(m_size), 32'd0);
      chk("ws_no_ack", 32'(d_ack), 32'd0);
      chk("ws_stall", 32'(d_stall), 32'd1);
      cycle(0);
    end
    m_ready = 1;
    @(negedge clk);
    chk("ws_ack", 32'(d_ack), 32'd1);
    cycle(0);
    d_req = 0;
    cycle(1);

    // Reset in the middle of a data access.
    d_req = 1; d_we = 0; d_addr = 32'h400; m_ready = 0;
    cycle(1); cycle(1);
    rst = 0;
    cycle(1);
    rst = 1; d_req = 0;
    @(negedge clk);
    chk("abort_m_req", 32'(m_req), 32'd0);
    chk("abort_no_ack", 32'(d_ack), 32'd0);
    cycle(0);

    // Random traffic: moderate, then heavy contention.
    repeat (1500) begin drive_rand(60, 60, 70, 1); cycle(1); end
    repeat (500)  begin drive_rand(95, 95, 90, 0); cycle(1); end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
